// File: rtl/dma_engine_if.sv
// dma_engine_if: groups the register-slave port and the master bus port of
// the DMA engine.
//   master : view taken by the DMA engine (it masters the memory bus)
//   slave  : view taken by the system side (decoder, arbiter, memory)
interface dma_engine_if;
  localparam int ARCH_WIDTH = 32;
  localparam int DMBE_WIDTH = 4;

  // register slave side
  logic                  cfg_sel;
  logic                  cfg_wr;
  logic [1:0]            cfg_addr;
  logic [ARCH_WIDTH-1:0] cfg_din;
  logic [31:0]           cfg_dout;

  // memory bus side
  logic                  m_req;
  logic                  m_gnt;
  logic [31:0]           m_addr;
  logic                  m_wr;
  logic [DMBE_WIDTH-1:0] m_BE;
  logic [31:0]           m_din;
  logic [31:0]           m_dout;

  // completion interrupt
  logic                  irq;

  modport master (
    input  cfg_sel, cfg_wr, cfg_addr, cfg_din, m_gnt, m_dout,
    output cfg_dout, m_req, m_addr, m_wr, m_BE, m_din, irq
  );

  modport slave (
    output cfg_sel, cfg_wr, cfg_addr, cfg_din, m_gnt, m_dout,
    input  cfg_dout, m_req, m_addr, m_wr, m_BE, m_din, irq
  );
endinterface

// File: rtl/dma_engine.sv
// dma_engine: word-copy DMA. Copies LEN 32-bit words from SRC to DST using
// one read then one write bus cycle per word.
// Register map (cfg_addr): 0=SRC, 1=DST, 2=LEN (low 16 bits), 3=CTRL.
// CTRL write: [31]=start, [30]=clear done, [29]=abort, [28]=ie.
// CTRL read : [0]=busy, [1]=done, [2]=ie, [31:16]=remaining word count.
// Optional feature macro: DMA_IRQ_EN (stores ie and drives a registered irq).
// Without it ie reads 0 and irq is tied low; software polls the done bit.
// Note: with DMA_IRQ_EN every CTRL write also rewrites ie from bit 28.
module dma_engine (
  input logic          clk,
  input logic          rst,
  dma_engine_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next_state;

  logic [31:0] r_src;
  logic [31:0] r_dst;
  logic [15:0] r_len;
  logic [31:0] r_wsrc;
  logic [31:0] r_wdst;
  logic [15:0] r_cnt;
  logic [31:0] r_buf;

  logic        w_cfg_wr;
  logic        w_ctrl_wr;
  logic        w_busy;
  logic        w_done;
  logic        w_start;
  logic        w_clear;
  logic        w_abort;
  logic        w_ie;

  assign w_cfg_wr  = bus.cfg_sel & bus.cfg_wr;
  assign w_ctrl_wr = w_cfg_wr & (bus.cfg_addr == 2'd3);
  assign w_busy    = (r_state == S_RD) | (r_state == S_WR);
  assign w_done    = (r_state == S_DONE);
  // start/clear are only honoured when idle or done; abort only when busy
  assign w_start   = w_ctrl_wr & bus.cfg_din[31] & ~w_busy;
  assign w_clear   = w_ctrl_wr & bus.cfg_din[30] & ~w_busy;
  assign w_abort   = w_ctrl_wr & bus.cfg_din[29] & w_busy;

`ifdef DMA_IRQ_EN
  logic r_ie;
  logic r_irq;
  logic w_ie_next;

  assign w_ie_next = w_ctrl_wr ? bus.cfg_din[28] : r_ie;

  // Interrupt enable storage and irq register aligned with entry into DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ie  <= 1'b0;
      r_irq <= 1'b0;
    end else begin
      r_ie  <= w_ie_next;
      r_irq <= (w_next_state == S_DONE) & w_ie_next;
    end
  end

  assign w_ie    = r_ie;
  assign bus.irq = r_irq;
`else
  assign w_ie    = 1'b0;
  assign bus.irq = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state logic; abort wins over a grant in the same cycle
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_start) begin
          w_next_state = (r_len != 16'd0) ? S_RD : S_DONE;
        end else if (w_clear) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_state = r_state;
        end
      end
      S_RD: begin
        if (w_abort) begin
          w_next_state = S_IDLE;
        end else if (bus.m_gnt) begin
          w_next_state = S_WR;
        end else begin
          w_next_state = S_RD;
        end
      end
      S_WR: begin
        if (w_abort) begin
          w_next_state = S_IDLE;
        end else if (bus.m_gnt) begin
          w_next_state = (r_cnt == 16'd1) ? S_DONE : S_RD;
        end else begin
          w_next_state = S_WR;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // FSM outputs: bus request, address, write strobe, byte enables, write data
  always_comb begin
    bus.m_req  = 1'b0;
    bus.m_addr = 32'd0;
    bus.m_wr   = 1'b0;
    bus.m_BE   = 4'b0000;
    bus.m_din  = 32'd0;
    case (r_state)
      S_RD: begin
        bus.m_req  = 1'b1;
        bus.m_addr = r_wsrc;
        bus.m_BE   = 4'b1111;
      end
      S_WR: begin
        bus.m_req  = 1'b1;
        bus.m_addr = r_wdst;
        bus.m_BE   = 4'b1111;
        bus.m_din  = r_buf;
        bus.m_wr   = bus.m_gnt;
      end
      default: begin
        bus.m_req  = 1'b0;
      end
    endcase
  end

  // Config registers, working copies and data buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_src  <= 32'd0;
      r_dst  <= 32'd0;
      r_len  <= 16'd0;
      r_wsrc <= 32'd0;
      r_wdst <= 32'd0;
      r_cnt  <= 16'd0;
      r_buf  <= 32'd0;
    end else begin
      if (w_cfg_wr && !w_busy) begin
        case (bus.cfg_addr)
          2'd0:    r_src <= bus.cfg_din;
          2'd1:    r_dst <= bus.cfg_din;
          2'd2:    r_len <= bus.cfg_din[15:0];
          default: r_len <= r_len;
        endcase
      end
      if (w_start) begin
        r_wsrc <= r_src;
        r_wdst <= r_dst;
        r_cnt  <= r_len;
      end else if (!w_abort && bus.m_gnt) begin
        if (r_state == S_RD) begin
          r_buf <= bus.m_dout;
        end else if (r_state == S_WR) begin
          r_wsrc <= r_wsrc + 32'd4;
          r_wdst <= r_wdst + 32'd4;
          r_cnt  <= r_cnt - 16'd1;
        end else begin
          r_buf <= r_buf;
        end
      end
    end
  end

  // Register read mux (combinational)
  always_comb begin
    bus.cfg_dout = 32'd0;
    case (bus.cfg_addr)
      2'd0:    bus.cfg_dout = r_src;
      2'd1:    bus.cfg_dout = r_dst;
      2'd2:    bus.cfg_dout = {16'd0, r_len};
      2'd3:    bus.cfg_dout = {r_cnt, 13'd0, w_ie, w_done, w_busy};
      default: bus.cfg_dout = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_dma_engine.sv
// tb_dma_engine: self-checking bench for dma_engine. Register vectors are
// table driven; bus cycles are checked against a scoreboard queue filled
// when a transfer is started.
module tb_dma_engine;

  logic clk;
  logic rst;
  dma_engine_if bus ();

  dma_engine u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef DMA_IRQ_EN
  localparam logic [31:0] IE_RD  = 32'h0000_0004;
  localparam logic        IRQ_ON = 1'b1;
`else
  localparam logic [31:0] IE_RD  = 32'h0000_0000;
  localparam logic        IRQ_ON = 1'b0;
`endif

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } bus_op_t;

  typedef struct packed {
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } reg_vec_t;

  bus_op_t sb[$];
  int      n_checks = 0;
  int      n_fail   = 0;
  int      n_bus    = 0;
  logic    req_seen = 1'b0;

  // memory model: read data is a fixed scramble of the address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'h3C3C};
  endfunction

  assign bus.m_dout = mem_word(bus.m_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // bus monitor: every completed bus cycle is compared with the scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.m_req) req_seen = 1'b1;
      if (!bus.m_gnt && bus.m_wr) begin
        n_checks++;
        n_fail++;
        $display("FAIL wr_without_gnt: got m_wr=1 expected 0");
      end
      if (bus.m_req && bus.m_gnt) begin
        bus_op_t e;
        n_bus++;
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_bus_cycle: got wr=%b addr=%h expected none", bus.m_wr, bus.m_addr);
        end else begin
          e = sb.pop_front();
          if (bus.m_wr !== e.wr || bus.m_addr !== e.addr || bus.m_BE !== 4'b1111 ||
              (e.wr && bus.m_din !== e.data)) begin
            n_fail++;
            $display("FAIL bus_cycle: got wr=%b addr=%h din=%h be=%b expected wr=%b addr=%h din=%h be=1111",
                     bus.m_wr, bus.m_addr, bus.m_din, bus.m_BE, e.wr, e.addr, e.data);
          end
        end
      end
    end
  end

  task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
    bus.cfg_sel  = 1'b1;
    bus.cfg_wr   = 1'b1;
    bus.cfg_addr = a;
    bus.cfg_din  = d;
    @(posedge clk);
    #1;
    bus.cfg_sel  = 1'b0;
    bus.cfg_wr   = 1'b0;
    bus.cfg_din  = 32'd0;
  endtask

  task automatic cfg_check(input string name, input logic [1:0] a, input logic [31:0] exp);
    bus.cfg_addr = a;
    #1;
    check(name, bus.cfg_dout, exp);
  endtask

  task automatic push_xfer(input logic [31:0] s, input logic [31:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] sa;
      sa = s + 32'(4 * i);
      sb.push_back({1'b0, sa, 32'd0});
      sb.push_back({1'b1, d + 32'(4 * i), mem_word(sa)});
    end
  endtask

  task automatic wait_done(input int max_cyc, output int waited);
    waited = -1;
    for (int i = 1; i <= max_cyc; i++) begin
      @(posedge clk);
      #1;
      bus.cfg_addr = 2'd3;
      #1;
      if (bus.cfg_dout[1]) begin
        waited = i;
        break;
      end
    end
    if (waited < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: got no done expected done within %0d cycles", max_cyc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    reg_vec_t vecs[6];
    int       w;
    int       nb;

    rst          = 1'b1;
    bus.cfg_sel  = 1'b0;
    bus.cfg_wr   = 1'b0;
    bus.cfg_addr = 2'd0;
    bus.cfg_din  = 32'd0;
    bus.m_gnt    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // reset state
    check("rst_m_req",  {31'd0, bus.m_req}, 32'd0);
    check("rst_m_wr",   {31'd0, bus.m_wr},  32'd0);
    check("rst_m_addr", bus.m_addr, 32'd0);
    check("rst_m_din",  bus.m_din,  32'd0);
    check("rst_m_be",   {28'd0, bus.m_BE}, 32'd0);
    check("rst_irq",    {31'd0, bus.irq}, 32'd0);
    cfg_check("rst_ctrl", 2'd3, 32'd0);
    cfg_check("rst_src",  2'd0, 32'd0);

    // register vectors: write then read back
    vecs[0] = '{2'd0, 32'h1234_5678, 32'h1234_5678};
    vecs[1] = '{2'd1, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[2] = '{2'd2, 32'hABCD_1234, 32'h0000_1234};
    vecs[3] = '{2'd2, 32'hFFFF_0000, 32'h0000_0000};
    vecs[4] = '{2'd3, 32'h1000_0000, IE_RD};
    vecs[5] = '{2'd3, 32'h0000_0000, 32'h0000_0000};
    foreach (vecs[i]) begin
      cfg_write(vecs[i].addr, vecs[i].wdata);
      cfg_check($sformatf("reg_vec%0d", i), vecs[i].addr, vecs[i].exp);
    end

    // basic 3-word copy with continuous grant
    bus.m_gnt = 1'b1;
    cfg_write(2'd0, 32'h0000_0100);
    cfg_write(2'd1, 32'h0000_0200);
    cfg_write(2'd2, 32'd3);
    push_xfer(32'h0000_0100, 32'h0000_0200, 3);
    nb = n_bus;
    cfg_write(2'd3, 32'h9000_0000);
    wait_done(40, w);
    check("t1_latency", w, 32'd6);
    check("t1_bus_cycles", n_bus - nb, 32'd6);
    check("t1_sb_empty", sb.size(), 32'd0);
    cfg_check("t1_ctrl", 2'd3, 32'h0000_0002 | IE_RD);
    check("t1_irq", {31'd0, bus.irq}, {31'd0, IRQ_ON});
    cfg_write(2'd3, 32'h5000_0000);
    check("t1_irq_clr", {31'd0, bus.irq}, 32'd0);
    cfg_check("t1_ctrl_clr", 2'd3, IE_RD);

    // zero length start: straight to done, no bus request
    cfg_write(2'd2, 32'd0);
    req_seen = 1'b0;
    cfg_write(2'd3, 32'h8000_0000);
    cfg_check("t2_ctrl", 2'd3, 32'h0000_0002);
    repeat (2) @(posedge clk);
    #1;
    check("t2_no_req", {31'd0, req_seen}, 32'd0);

    // start+clear from done executes the start
    cfg_write(2'd0, 32'h0000_0800);
    cfg_write(2'd1, 32'h0000_0900);
    cfg_write(2'd2, 32'd1);
    push_xfer(32'h0000_0800, 32'h0000_0900, 1);
    bus.m_gnt = 1'b0;
    cfg_write(2'd3, 32'hC000_0000);
    cfg_check("t3_ctrl_busy", 2'd3, 32'h0001_0001);

    // grant stall in RD: address held, no advance, writes ignored
    for (int i = 0; i < 5; i++) begin
      check("t4_addr_hold", bus.m_addr, 32'h0000_0800);
      check("t4_req", {31'd0, bus.m_req}, 32'd1);
      @(posedge clk);
      #1;
    end
    cfg_write(2'd0, 32'h0000_0BAD);
    cfg_write(2'd3, 32'h8000_0000);
    cfg_check("t4_src_kept", 2'd0, 32'h0000_0800);
    cfg_check("t4_still_rd", 2'd3, 32'h0001_0001);
    bus.m_gnt = 1'b1;
    wait_done(20, w);
    check("t4_latency", w, 32'd2);
    check("t4_sb_empty", sb.size(), 32'd0);

    // address wrap past 0xFFFFFFFC
    cfg_write(2'd0, 32'hFFFF_FFFC);
    cfg_write(2'd1, 32'h0000_0300);
    cfg_write(2'd2, 32'd2);
    push_xfer(32'hFFFF_FFFC, 32'h0000_0300, 2);
    cfg_write(2'd3, 32'h8000_0000);
    wait_done(20, w);
    check("t5_latency", w, 32'd4);
    check("t5_sb_empty", sb.size(), 32'd0);

    // abort after first word of a 4-word transfer
    cfg_write(2'd0, 32'h0000_0400);
    cfg_write(2'd1, 32'h0000_0500);
    cfg_write(2'd2, 32'd4);
    push_xfer(32'h0000_0400, 32'h0000_0500, 1);
    nb = n_bus;
    cfg_write(2'd3, 32'h8000_0000);
    @(posedge clk);
    @(posedge clk);
    #1;
    bus.m_gnt = 1'b0;
    cfg_write(2'd3, 32'h2000_0000);
    cfg_check("t6_ctrl", 2'd3, 32'h0003_0000);
    bus.m_gnt = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("t6_bus_cycles", n_bus - nb, 32'd2);
    check("t6_no_req", {31'd0, bus.m_req}, 32'd0);
    check("t6_sb_empty", sb.size(), 32'd0);

    // reset mid-transfer abandons it
    cfg_write(2'd2, 32'd3);
    push_xfer(32'h0000_0400, 32'h0000_0500, 3);
    cfg_write(2'd3, 32'h8000_0000);
    @(posedge clk);
    #1;
    sb.delete();
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("t7_req_in_rst", {31'd0, bus.m_req}, 32'd0);
    check("t7_addr_in_rst", bus.m_addr, 32'd0);
    rst = 1'b0;
    nb = n_bus;
    repeat (4) @(posedge clk);
    #1;
    check("t7_no_bus", n_bus - nb, 32'd0);
    cfg_check("t7_ctrl", 2'd3, 32'd0);
    cfg_check("t7_len", 2'd2, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
